if_stage: RTL

- Instruction-fetch stage of the OpenMIPS pipeline. Sits directly upstream of the instruction ROM, whose read is combinational and indexed by a 6-bit word address.
- Holds the program counter and drives the ROM enable and word address.
- Captures the returned instruction, with its PC, into the IF/ID pipeline register for decode.
- Handles pipeline stall, flush/exception redirect and branch redirect, and keeps a count of fetches.

---
 rtl/if_stage_if.sv | 30 +++
 rtl/if_stage.sv | 102 ++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Signal bundle between the instruction-fetch stage and its surroundings:
// pipeline control, ROM port and IF/ID outputs.
interface if_stage_if #(
    parameter int ROM_AW = 6
);
    logic              stall_if;
    logic              stall_id;
    logic              branch_flag;
    logic [31:0]       branch_target;
    logic              flush;
    logic [31:0]       flush_pc;
    logic [31:0]       inst_i;
    logic              rom_ce;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       pc;
    logic [31:0]       id_pc;
    logic [31:0]       id_inst;
    logic              id_valid;
    logic [31:0]       fetch_count;

    modport master (
        input  stall_if, stall_id, branch_flag, branch_target, flush, flush_pc, inst_i,
        output rom_ce, rom_addr, pc, id_pc, id_inst, id_valid, fetch_count
    );

    modport slave (
        output stall_if, stall_id, branch_flag, branch_target, flush, flush_pc, inst_i,
        input  rom_ce, rom_addr, pc, id_pc, id_inst, id_valid, fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// OpenMIPS instruction-fetch stage: PC register, ROM enable/address,
// IF/ID pipeline register and accepted-fetch counter.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ROM_AW   = 6
) (
    input  logic          clk,
    input  logic          rst,
    if_stage_if.master    bus
);
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic        ce_r;
    logic [31:0] pc_r;
    logic [31:0] id_pc_r;
    logic [31:0] id_inst_r;
    logic        id_valid_r;
    logic [31:0] fetch_count_r;

    logic [31:0] pc_next_s;
    logic [31:0] id_pc_next_s;
    logic [31:0] id_inst_next_s;
    logic        id_valid_next_s;
    logic [31:0] fetch_count_next_s;
    logic        stall_any_s;

    // A decode stall must also freeze fetch, otherwise the held instruction is lost.
    assign stall_any_s = bus.stall_if | bus.stall_id;

    // Next-PC selection: flush beats stall beats branch beats sequential.
    always_comb begin
        pc_next_s = pc_r;
        if (!ce_r) begin
            pc_next_s = RESET_PC_ALIGNED;
        end else if (bus.flush) begin
            pc_next_s = {bus.flush_pc[31:2], 2'b00};
        end else if (stall_any_s) begin
            pc_next_s = pc_r;
        end else if (bus.branch_flag) begin
            pc_next_s = {bus.branch_target[31:2], 2'b00};
        end else begin
            pc_next_s = pc_r + 32'd4;
        end
    end

    // IF/ID next values and fetch counter; only an accepted real fetch counts.
    always_comb begin
        id_pc_next_s       = id_pc_r;
        id_inst_next_s     = id_inst_r;
        id_valid_next_s    = id_valid_r;
        fetch_count_next_s = fetch_count_r;
        if (bus.flush) begin
            id_pc_next_s    = 32'd0;
            id_inst_next_s  = 32'd0;
            id_valid_next_s = 1'b0;
        end else if (bus.stall_id) begin
            id_pc_next_s    = id_pc_r;
            id_inst_next_s  = id_inst_r;
            id_valid_next_s = id_valid_r;
        end else if (bus.stall_if) begin
            id_pc_next_s    = 32'd0;
            id_inst_next_s  = 32'd0;
            id_valid_next_s = 1'b0;
        end else begin
            id_pc_next_s    = pc_r;
            id_inst_next_s  = ce_r ? bus.inst_i : 32'd0;
            id_valid_next_s = ce_r;
            if (ce_r) begin
                fetch_count_next_s = fetch_count_r + 32'd1;
            end else begin
                fetch_count_next_s = fetch_count_r;
            end
        end
    end

    // State registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_r          <= 1'b0;
            pc_r          <= RESET_PC_ALIGNED;
            id_pc_r       <= 32'd0;
            id_inst_r     <= 32'd0;
            id_valid_r    <= 1'b0;
            fetch_count_r <= 32'd0;
        end else begin
            ce_r          <= 1'b1;
            pc_r          <= pc_next_s;
            id_pc_r       <= id_pc_next_s;
            id_inst_r     <= id_inst_next_s;
            id_valid_r    <= id_valid_next_s;
            fetch_count_r <= fetch_count_next_s;
        end
    end

    assign bus.rom_ce      = ce_r;
    assign bus.rom_addr    = pc_r[ROM_AW+1:2];
    assign bus.pc          = pc_r;
    assign bus.id_pc       = id_pc_r;
    assign bus.id_inst     = id_inst_r;
    assign bus.id_valid    = id_valid_r;
    assign bus.fetch_count = fetch_count_r;
endmodule
